// File: rtl/bonus_fall_ctrl_if.sv
// Signal bundle between game control and the falling-bonus controller.
// The master side drives spawn/frame/hit/clear; the slave side returns position and pulses.
interface bonus_fall_ctrl_if;
  logic        startOfFrame;
  logic        spawn;
  logic [10:0] spawnX;
  logic [10:0] spawnY;
  logic        paddleHit;
  logic        clear;
  logic [10:0] topLeftMoveX;
  logic [10:0] topLeftMoveY;
  logic        bonusActive;
  logic        caughtPulse;
  logic        missedPulse;

  modport master (
    output startOfFrame, spawn, spawnX, spawnY, paddleHit, clear,
    input  topLeftMoveX, topLeftMoveY, bonusActive, caughtPulse, missedPulse
  );

  modport slave (
    input  startOfFrame, spawn, spawnX, spawnY, paddleHit, clear,
    output topLeftMoveX, topLeftMoveY, bonusActive, caughtPulse, missedPulse
  );
endinterface

// File: rtl/bonus_fall_ctrl.sv
// Falling bonus motion controller: latches a spawn point, drops once per frame with
// stepped acceleration, and reports catch or miss as single-cycle pulses.
module bonus_fall_ctrl #(
  parameter int INIT_SPEED   = 2,
  parameter int MAX_SPEED    = 8,
  parameter int ACCEL_PERIOD = 16,
  parameter int SCREEN_H     = 480,
  parameter int OBJ_HEIGHT   = 16
) (
  input  logic               clk,
  input  logic               resetN,
  bonus_fall_ctrl_if.slave   bus
);

  localparam int FloorY = SCREEN_H - OBJ_HEIGHT;
  localparam int CntW   = (ACCEL_PERIOD > 1) ? $clog2(ACCEL_PERIOD) : 1;
  localparam int SpdW   = $clog2(MAX_SPEED + 1);

  typedef enum logic [1:0] {S_IDLE, S_FALLING, S_CAUGHT, S_MISSED} state_e;

  state_e            state_q, state_d;
  logic [10:0]       x_q, x_d;
  logic [10:0]       y_q, y_d;
  logic [SpdW-1:0]   speed_q, speed_d;
  logic [CntW-1:0]   frame_cnt_q, frame_cnt_d;
  logic              active_q, active_d;
  logic              caught_q, caught_d;
  logic              missed_q, missed_d;
  logic [11:0]       next_y;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    speed_d     = speed_q;
    frame_cnt_d = frame_cnt_q;
    // One extra bit so a spawn near the bottom cannot wrap past the floor check.
    next_y      = {1'b0, y_q} + 12'(speed_q);

    if (bus.clear) begin
      state_d     = S_IDLE;
      speed_d     = SpdW'(INIT_SPEED);
      frame_cnt_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.spawn) begin
            x_d         = bus.spawnX;
            y_d         = bus.spawnY;
            speed_d     = SpdW'(INIT_SPEED);
            frame_cnt_d = '0;
            state_d     = S_FALLING;
          end
        end
        S_FALLING: begin
          if (bus.paddleHit) begin
            state_d = S_CAUGHT;
          end else if (bus.startOfFrame) begin
            if (frame_cnt_q == CntW'(ACCEL_PERIOD - 1)) begin
              frame_cnt_d = '0;
              if (speed_q < SpdW'(MAX_SPEED)) speed_d = speed_q + 1'b1;
            end else begin
              frame_cnt_d = frame_cnt_q + 1'b1;
            end
            if (next_y > 12'(FloorY)) begin
              y_d     = 11'(FloorY);
              state_d = S_MISSED;
            end else begin
              y_d = next_y[10:0];
            end
          end
        end
        S_CAUGHT, S_MISSED: state_d = S_IDLE;
        default:            state_d = S_IDLE;
      endcase
    end

    // Outputs are registered copies of the next state so they never glitch.
    active_d = (state_d == S_FALLING);
    caught_d = (state_d == S_CAUGHT);
    missed_d = (state_d == S_MISSED);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q     <= S_IDLE;
      x_q         <= '0;
      y_q         <= '0;
      speed_q     <= SpdW'(INIT_SPEED);
      frame_cnt_q <= '0;
      active_q    <= 1'b0;
      caught_q    <= 1'b0;
      missed_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      speed_q     <= speed_d;
      frame_cnt_q <= frame_cnt_d;
      active_q    <= active_d;
      caught_q    <= caught_d;
      missed_q    <= missed_d;
    end
  end

  assign bus.topLeftMoveX = x_q;
  assign bus.topLeftMoveY = y_q;
  assign bus.bonusActive  = active_q;
  assign bus.caughtPulse  = caught_q;
  assign bus.missedPulse  = missed_q;

endmodule

// File: tb/tb_bonus_fall_ctrl.sv
// Scoreboard bench for bonus_fall_ctrl: a drop-level reference model queues the expected
// outputs for every clocked cycle and a negedge monitor compares them against the DUT.
module tb_bonus_fall_ctrl;
  localparam int INIT  = 2;
  localparam int MAXS  = 8;
  localparam int ACCEL = 16;
  localparam int FLOOR = 480 - 16;

  typedef struct {
    int x;
    int y;
    bit act;
    bit c;
    bit m;
  } exp_t;

  logic clk;
  logic resetN;
  bonus_fall_ctrl_if bus ();

  bonus_fall_ctrl dut (
    .clk   (clk),
    .resetN(resetN),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  exp_t exp_q[$];
  int   n_pass  = 0;
  int   n_total = 0;

  // Reference model: one drop at a time, tracked with plain integers.
  bit m_fall, m_c, m_m;
  int m_x, m_y, m_speed, m_frames;

  task automatic check(string name, int act, int expv);
    n_total++;
    if (act == expv) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
  endtask

  task automatic model_reset();
    m_fall = 0; m_c = 0; m_m = 0;
    m_x = 0; m_y = 0; m_speed = INIT; m_frames = 0;
  endtask

  task automatic model_step(bit sof, bit sp, int sx, int sy, bit hit, bit clr);
    bit was_pulse;
    was_pulse = m_c || m_m;
    m_c = 0;
    m_m = 0;
    if (clr) begin
      m_fall = 0; m_speed = INIT; m_frames = 0;
    end else if (m_fall) begin
      if (hit) begin
        m_fall = 0; m_c = 1;
      end else if (sof) begin
        int nxt;
        nxt = m_y + m_speed;
        m_frames++;
        if (m_frames == ACCEL) begin
          m_frames = 0;
          if (m_speed < MAXS) m_speed++;
        end
        if (nxt > FLOOR) begin
          m_y = FLOOR; m_fall = 0; m_m = 1;
        end else begin
          m_y = nxt;
        end
      end
    end else if (!was_pulse && sp) begin
      m_x = sx; m_y = sy; m_speed = INIT; m_frames = 0; m_fall = 1;
    end
    exp_q.push_back('{m_x, m_y, m_fall, m_c, m_m});
  endtask

  // Drive one cycle of inputs just after the falling edge and queue what the next edge should produce.
  task automatic tick(bit sof, bit sp, int sx, int sy, bit hit, bit clr);
    @(negedge clk);
    #1;
    bus.startOfFrame = sof;
    bus.spawn        = sp;
    bus.spawnX       = 11'(sx);
    bus.spawnY       = 11'(sy);
    bus.paddleHit    = hit;
    bus.clear        = clr;
    model_step(sof, sp, sx, sy, hit, clr);
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) tick(0, 0, 0, 0, 0, 0);
  endtask

  task automatic frame(int n);
    for (int i = 0; i < n; i++) begin
      tick(1, 0, 0, 0, 0, 0);
      tick(0, 0, 0, 0, 0, 0);
    end
  endtask

  task automatic zero_inputs();
    bus.startOfFrame = 0; bus.spawn = 0; bus.spawnX = '0; bus.spawnY = '0;
    bus.paddleHit = 0; bus.clear = 0;
  endtask

  task automatic check_all_zero(string tag);
    check({tag, "_x"},      int'(bus.topLeftMoveX), 0);
    check({tag, "_y"},      int'(bus.topLeftMoveY), 0);
    check({tag, "_active"}, int'(bus.bonusActive), 0);
    check({tag, "_caught"}, int'(bus.caughtPulse), 0);
    check({tag, "_missed"}, int'(bus.missedPulse), 0);
  endtask

  // Monitor: compares the DUT against the oldest queued expectation after every clocked edge.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("x",      int'(bus.topLeftMoveX), e.x);
      check("y",      int'(bus.topLeftMoveY), e.y);
      check("active", int'(bus.bonusActive), int'(e.act));
      check("caught", int'(bus.caughtPulse), int'(e.c));
      check("missed", int'(bus.missedPulse), int'(e.m));
      if (bus.caughtPulse && bus.missedPulse)
        check("pulse_exclusive", 1, 0);
    end
  end

  initial begin
    zero_inputs();
    model_reset();
    resetN = 1'b0;
    #13;
    check_all_zero("reset");
    @(negedge clk);
    #1 resetN = 1'b1;

    // Spawn at (100,50) then three frames: Y 52, 54, 56.
    tick(0, 1, 100, 50, 0, 0);
    frame(3);
    // Spawn while falling is ignored.
    tick(0, 1, 700, 10, 0, 0);
    // Enough frames to cross two acceleration steps.
    frame(40);
    // Clear while falling aborts without a pulse.
    tick(0, 0, 0, 0, 0, 1);
    idle(2);

    // Catch on the same cycle as a frame tick: Y stays 400.
    tick(0, 1, 300, 400, 0, 0);
    tick(1, 0, 0, 0, 1, 0);
    idle(3);

    // Bottom approach: 460 -> 462 -> 464 -> clamp at 464 with a miss.
    tick(0, 1, 20, 460, 0, 0);
    frame(4);
    // Spawn below the floor misses on the first frame.
    tick(0, 1, 33, 470, 0, 0);
    frame(2);

    // Hit and clear outside FALLING; clear beats spawn.
    tick(0, 0, 0, 0, 1, 0);
    tick(0, 1, 5, 5, 0, 1);
    idle(2);

    // Long drop from the top, a frame every cycle: reaches the speed ceiling then misses.
    tick(0, 1, 1, 0, 0, 0);
    for (int i = 0; i < 110; i++) tick(1, 0, 0, 0, 0, 0);
    idle(2);

    // Reset mid-fall at Y=200.
    tick(0, 1, 10, 190, 0, 0);
    frame(5);
    @(negedge clk);
    #1;
    zero_inputs();
    resetN = 1'b0;
    model_reset();
    #1;
    check_all_zero("async_reset");
    repeat (2) @(negedge clk);
    #1 resetN = 1'b1;
    idle(2);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      tick(($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0),
           int'($urandom_range(0, 2047)), int'($urandom_range(0, 480)),
           ($urandom_range(0, 39) == 0), ($urandom_range(0, 99) == 0));
    end
    idle(2);

    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    check("scoreboard_drain", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
